// File: rtl/pc_sequencer.sv
// Program-counter / writeback sequencer for the pico MIPS core.
// Chooses +1, relative branch or hold each cycle; holds for multiply, input wait and halt.
module pc_sequencer #(
    parameter int AddrSz    = 6,
    parameter int MulCycles = 3
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              stall,
    input  logic              instr_branch,
    input  logic              branch_cond,
    input  logic              instr_mul,
    input  logic              instr_wait,
    input  logic              instr_halt,
    input  logic [AddrSz-1:0] imm_offset,
    input  logic              in_valid,
    output logic              pc_en,
    output logic              rel_branch,
    output logic [AddrSz-1:0] offset,
    output logic              reg_we,
    output logic              in_ack,
    output logic              mul_busy,
    output logic              halted
);

    localparam int CW = $clog2(MulCycles) + 1;
    // The first multiply cycle is spent in RUN, so the counter covers the remaining ones.
    localparam logic [CW-1:0] MUL_LOAD = (MulCycles > 1) ? CW'(MulCycles - 2) : '0;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MUL  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en      = 1'b0;
        rel_branch = 1'b0;
        reg_we     = 1'b0;
        in_ack     = 1'b0;
        mul_busy   = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    if (instr_halt) begin
                        state_d = S_HALT;
                    end else if (instr_mul) begin
                        if (MulCycles == 1) begin
                            pc_en  = 1'b1;
                            reg_we = 1'b1;
                        end else begin
                            mul_busy = 1'b1;
                            cnt_d    = MUL_LOAD;
                            state_d  = S_MUL;
                        end
                    end else if (instr_wait) begin
                        if (in_valid) begin
                            in_ack = 1'b1;
                            pc_en  = 1'b1;
                            reg_we = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else if (instr_branch) begin
                        pc_en      = 1'b1;
                        rel_branch = branch_cond;
                    end else begin
                        pc_en  = 1'b1;
                        reg_we = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_busy = 1'b1;
                if (cnt_q == '0) begin
                    pc_en   = 1'b1;
                    reg_we  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    in_ack  = 1'b1;
                    pc_en   = 1'b1;
                    reg_we  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                halted = 1'b1;
            end
        endcase

        // Outputs are combinational, so they must be forced quiet while reset is held.
        if (!n_reset) begin
            pc_en      = 1'b0;
            rel_branch = 1'b0;
            reg_we     = 1'b0;
            in_ack     = 1'b0;
            mul_busy   = 1'b0;
            halted     = 1'b0;
        end

        offset = rel_branch ? imm_offset : '0;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected output vectors are queued with each
// stimulus cycle and compared on the following falling clock edge.
module tb_pc_sequencer;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          stall, instr_branch, branch_cond, instr_mul, instr_wait, instr_halt;
    logic [AW-1:0] imm_offset;
    logic          in_valid;
    logic          pc_en, rel_branch, reg_we, in_ack, mul_busy, halted;
    logic [AW-1:0] offset;

    // Flag word layout: {stall, branch, cond, mul, wait, halt, in_valid}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_ST   = 7'b1000000;
    localparam logic [6:0] F_BR   = 7'b0100000;
    localparam logic [6:0] F_CD   = 7'b0010000;
    localparam logic [6:0] F_MU   = 7'b0001000;
    localparam logic [6:0] F_WT   = 7'b0000100;
    localparam logic [6:0] F_HL   = 7'b0000010;
    localparam logic [6:0] F_IV   = 7'b0000001;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer #(.AddrSz(AW), .MulCycles(3)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .stall        (stall),
        .instr_branch (instr_branch),
        .branch_cond  (branch_cond),
        .instr_mul    (instr_mul),
        .instr_wait   (instr_wait),
        .instr_halt   (instr_halt),
        .imm_offset   (imm_offset),
        .in_valid     (in_valid),
        .pc_en        (pc_en),
        .rel_branch   (rel_branch),
        .offset       (offset),
        .reg_we       (reg_we),
        .in_ack       (in_ack),
        .mul_busy     (mul_busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Packs {pc_en, rel_branch, offset, reg_we, in_ack, mul_busy, halted}
    function automatic logic [12:0] ev(input bit pc, input bit rel, input logic [5:0] off,
                                       input bit we, input bit ack, input bit busy, input bit hlt);
        return {pc, rel, off, we, ack, busy, hlt};
    endfunction

    task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [12:0] obs;
            e   = exp_q.pop_front();
            obs = {pc_en, rel_branch, offset, reg_we, in_ack, mul_busy, halted};
            $display("txn %-12s pc_en=%b rel=%b off=%0d we=%b ack=%b busy=%b halted=%b",
                     e.tag, pc_en, rel_branch, offset, reg_we, in_ack, mul_busy, halted);
            check_eq(e.tag, obs, e.v);
        end
    end

    task automatic cyc(input string tag, input bit rst_v, input logic [6:0] f,
                       input logic [5:0] imm, input logic [12:0] expv);
        exp_t e;
        @(posedge clk);
        #1;
        n_reset      = rst_v;
        stall        = f[6];
        instr_branch = f[5];
        branch_cond  = f[4];
        instr_mul    = f[3];
        instr_wait   = f[2];
        instr_halt   = f[1];
        in_valid     = f[0];
        imm_offset   = imm;
        e.tag = tag;
        e.v   = expv;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [12:0] z;
        logic [12:0] plain;
        logic [12:0] ack;
        logic [12:0] busy;
        logic [12:0] busy_done;
        int          drain;
        z         = ev(0, 0, 6'd0, 0, 0, 0, 0);
        plain     = ev(1, 0, 6'd0, 1, 0, 0, 0);
        ack       = ev(1, 0, 6'd0, 1, 1, 0, 0);
        busy      = ev(0, 0, 6'd0, 0, 0, 1, 0);
        busy_done = ev(1, 0, 6'd0, 1, 0, 1, 0);

        n_reset = 1'b0;
        {stall, instr_branch, branch_cond, instr_mul, instr_wait, instr_halt, in_valid} = '0;
        imm_offset = '0;

        cyc("rst_plain", 0, F_NONE, 6'd0, z);
        cyc("rst_branch", 0, F_BR | F_CD, 6'd10, z);

        for (int i = 0; i < 4; i++) cyc("plain", 1, F_NONE, 6'd0, plain);

        cyc("br_taken", 1, F_BR | F_CD, 6'd10, ev(1, 1, 6'd10, 0, 0, 0, 0));
        cyc("br_nottaken", 1, F_BR, 6'd10, ev(1, 0, 6'd0, 0, 0, 0, 0));
        cyc("br_neg", 1, F_BR | F_CD, 6'h3f, ev(1, 1, 6'h3f, 0, 0, 0, 0));

        cyc("stall_br", 1, F_ST | F_BR | F_CD, 6'd7, z);
        cyc("stall_mul", 1, F_ST | F_MU, 6'd0, z);
        cyc("stall_plain", 1, F_ST, 6'd0, z);

        cyc("mul_c1", 1, F_MU, 6'd0, busy);
        cyc("mul_c2", 1, F_ST | F_BR | F_CD, 6'd3, busy);
        cyc("mul_c3", 1, F_ST, 6'd0, busy_done);
        cyc("mul_after", 1, F_NONE, 6'd0, plain);

        cyc("wait_c1", 1, F_WT, 6'd0, z);
        for (int i = 0; i < 3; i++) cyc("wait_hold", 1, F_NONE, 6'd0, z);
        cyc("wait_stall", 1, F_ST, 6'd0, z);
        cyc("wait_ack", 1, F_IV, 6'd0, ack);
        cyc("wait_after", 1, F_IV, 6'd0, plain);

        cyc("wait_fast", 1, F_WT | F_IV, 6'd0, ack);
        cyc("wait_fast_nx", 1, F_IV, 6'd0, plain);

        cyc("prio_mul", 1, F_MU | F_WT | F_BR | F_CD | F_IV, 6'd5, busy);
        cyc("prio_mul2", 1, F_NONE, 6'd0, busy);
        cyc("prio_mul3", 1, F_NONE, 6'd0, busy_done);
        cyc("prio_wait", 1, F_WT | F_BR | F_CD | F_IV, 6'd5, ack);

        cyc("halt_mul", 1, F_HL | F_MU, 6'd0, z);
        for (int i = 0; i < 20; i++)
            cyc("halted", 1, 7'($urandom), 6'($urandom), ev(0, 0, 6'd0, 0, 0, 0, 1));
        cyc("halt_rst", 0, F_NONE, 6'd0, z);
        cyc("halt_exit", 1, F_NONE, 6'd0, plain);

        cyc("rmul_c1", 1, F_MU, 6'd0, busy);
        cyc("rmul_rst", 0, F_NONE, 6'd0, z);
        cyc("rmul_exit", 1, F_NONE, 6'd0, plain);
        cyc("rmul_plain", 1, F_NONE, 6'd0, plain);

        cyc("rwait_c1", 1, F_WT, 6'd0, z);
        cyc("rwait_hold", 1, F_NONE, 6'd0, z);
        cyc("rwait_rst", 0, F_IV, 6'd0, z);
        cyc("rwait_exit", 1, F_IV, 6'd0, plain);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        check_eq("drain", 13'(exp_q.size()), 13'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
